load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_align.sv | 48 ++++
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 tb/tb_load_store_unit.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: access size and FSM
// state encodings, lane masks, and the helper that positions a lane in a word.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    localparam logic [31:0] LANE_MASK_BYTE = 32'h0000_00FF;
    localparam logic [31:0] LANE_MASK_HALF = 32'h0000_FFFF;
    localparam logic [31:0] LANE_MASK_WORD = 32'hFFFF_FFFF;

    // Bit offset of the addressed lane; halfwords snap to addr[1] and words
    // to bit 0, so unaligned low address bits are simply ignored here.
    function automatic logic [4:0] lane_shift(input lsu_size_e size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return {addr_lo, 3'b000};
            SZ_HALF: return {addr_lo[1], 4'b0000};
            default: return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment for the load/store unit: extracts and
// sign/zero-extends a load lane from a memory word, and merges store data
// into the addressed lane of a previously read word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rd_word,
    input  logic [31:0] i_buf_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_store_word
);

    lsu_size_e   w_size;
    logic [4:0]  w_shamt;
    logic [31:0] w_lane;
    logic [31:0] w_mask;

    assign w_size  = lsu_size_e'(i_size);
    assign w_shamt = lane_shift(w_size, i_addr_lo);
    assign w_lane  = i_rd_word >> w_shamt;

    // Load path: right-justify the addressed lane, then extend it.
    always_comb begin
        o_load_data = 32'h0;
        case (w_size)
            SZ_BYTE: o_load_data = {{24{w_lane[7] & ~i_unsigned}}, w_lane[7:0]};
            SZ_HALF: o_load_data = {{16{w_lane[15] & ~i_unsigned}}, w_lane[15:0]};
            SZ_WORD: o_load_data = i_rd_word;
            default: o_load_data = 32'h0;
        endcase
    end

    // Store path: replace only the addressed lane of the buffered word.
    always_comb begin
        w_mask = LANE_MASK_WORD;
        case (w_size)
            SZ_BYTE: w_mask = LANE_MASK_BYTE;
            SZ_HALF: w_mask = LANE_MASK_HALF;
            default: w_mask = LANE_MASK_WORD;
        endcase
        o_store_word = (i_buf_word & ~(w_mask << w_shamt)) | ((i_wdata & w_mask) << w_shamt);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between a core request/response port and a word-wide
// data memory with combinational read. Sub-word stores do read-modify-write.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned halfword/word accesses
// are rejected as errors instead of being aligned down.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid-side fields are only looked at in that cycle.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    output logic [1:0]  o_dbg_state
);

    localparam logic [32:0] ADDR_LIMIT = 33'(ADDR_WORDS) << 2;

    lsu_state_e  r_state;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;
    logic        r_mem_we;
    logic [31:0] r_buf;
    logic        r_we;
    lsu_size_e   r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    lsu_size_e   w_req_size;
    logic        w_addr_err;
    logic        w_misalign;
    logic        w_req_err;
    logic [31:0] w_load_data;
    logic [31:0] w_store_word;

    assign w_req_size = lsu_size_e'(req_size);
    assign w_addr_err = {1'b0, req_addr} >= ADDR_LIMIT;
`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((w_req_size == SZ_HALF) && req_addr[0]) ||
                        ((w_req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif
    assign w_req_err = (w_req_size == SZ_RSVD) || w_addr_err || w_misalign;

    lsu_align u_align (
        .i_size       (r_size),
        .i_unsigned   (r_unsigned),
        .i_addr_lo    (r_addr[1:0]),
        .i_rd_word    (mem_rd),
        .i_buf_word   (r_buf),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word)
    );

    // Request FSM: latch on accept, sequence memory access, hold response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_mem_we    <= 1'b0;
            r_buf       <= 32'h0;
            r_we        <= 1'b0;
            r_size      <= SZ_BYTE;
            r_unsigned  <= 1'b0;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_we        <= req_we;
                        r_size      <= w_req_size;
                        r_unsigned  <= req_unsigned;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        if (w_req_err) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= 32'h0;
                        end else if (req_we && (w_req_size == SZ_WORD)) begin
                            r_state  <= ST_WRITE;
                            r_mem_we <= 1'b1;
                        end else begin
                            r_state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    r_buf <= mem_rd;
                    if (r_we) begin
                        r_state  <= ST_WRITE;
                        r_mem_we <= 1'b1;
                    end else begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= w_load_data;
                    end
                end
                ST_WRITE: begin
                    r_mem_we    <= 1'b0;
                    r_state     <= ST_RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= 32'h0;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_req_ready <= 1'b1;
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= 32'h0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_mem_we    <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_err     = r_rsp_err;
    assign rsp_rdata   = r_rsp_rdata;
    assign mem_we      = r_mem_we;
    assign mem_addr    = {2'b00, r_addr[31:2]};
    assign mem_wd      = w_store_word;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset/hold sequences,
// then randomized requests checked against a byte-level memory model.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int AW = 32;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic [1:0]  dbg_state;

    load_store_unit #(.ADDR_WORDS(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd),
        .o_dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- data memory environment ----------------
    logic [31:0] mem [AW];
    bit          mem_inited;
    int          we_count;
    logic [31:0] last_wa;
    logic [31:0] last_wd;

    assign mem_rd = (mem_addr < 32'(AW)) ? mem[mem_addr[4:0]] : 32'h0;

    always @(negedge clk) begin
        if (!mem_inited) begin
            for (int i = 0; i < AW; i++) mem[i] <= 32'(i);
            mem_inited <= 1'b1;
        end else if (mem_we) begin
            we_count <= we_count + 1;
            last_wa  <= mem_addr;
            last_wd  <= mem_wd;
            if (mem_addr < 32'(AW)) mem[mem_addr[4:0]] <= mem_wd;
        end
    end

    // ---------------- scoreboard ----------------
    int          n_checks;
    int          n_pass;
    logic [31:0] exp_q[$];
    logic [31:0] ref_mem [AW];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    // Reference model: byte-granular view of memory, natural lane alignment.
    task automatic model_req(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic err, output logic [31:0] rdata, output int lat,
                             output int wcnt, output logic [31:0] wa, output logic [31:0] wd);
        int unsigned idx, off, nbytes;
        logic [31:0] val;
        idx = addr / 4;
        off = addr % 4;
        err = (size == 2'd3) || (addr >= 32'(4 * AW));
`ifdef LSU_MISALIGN_TRAP_EN
        if ((size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0)) err = 1'b1;
`endif
        rdata = 32'h0; wcnt = 0; wa = 32'h0; wd = 32'h0; lat = 1;
        if (err) return;
        nbytes = 1 << size;
        off = (off / nbytes) * nbytes;
        if (!we) begin
            val = 32'h0;
            for (int b = 0; b < 4; b++)
                if (b < int'(nbytes)) val[8*b +: 8] = ref_mem[idx][8*(int'(off)+b) +: 8];
            if (!uns && nbytes < 4 && val[8*nbytes-1])
                for (int b = 0; b < 4; b++)
                    if (b >= int'(nbytes)) val[8*b +: 8] = 8'hFF;
            rdata = val;
            lat = 2;
        end else begin
            val = ref_mem[idx];
            for (int b = 0; b < 4; b++)
                if (b < int'(nbytes)) val[8*(int'(off)+b) +: 8] = wdata[8*b +: 8];
            ref_mem[idx] = val;
            wcnt = 1; wa = idx; wd = val;
            lat = (nbytes == 4) ? 2 : 3;
        end
    endtask

    // ---------------- driver ----------------
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                          output logic err, output logic [31:0] rdata, output int lat,
                          output int wcnt, output logic [31:0] wa, output logic [31:0] wd,
                          output logic stable_ok);
        int n;
        int start_we;
        err = 1'bx; rdata = 32'hx; lat = -1; wcnt = -1; wa = 32'h0; wd = 32'h0; stable_ok = 1'b0;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (!req_ready) return;
        start_we = we_count;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk); lat = 1; #1;
        // Scramble inputs after accept; the latched request must not change.
        req_valid = 1'b0; req_we = ~we; req_size = 2'($urandom); req_unsigned = ~uns;
        req_addr = $urandom; req_wdata = $urandom;
        while (!rsp_valid && lat < 10) begin @(posedge clk); lat++; #1; end
        if (!rsp_valid) begin lat = -1; return; end
        rdata = rsp_rdata;
        err = rsp_err;
        stable_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (req_ready) stable_ok = 1'b0;
            @(posedge clk); #1;
            if (!rsp_valid || rsp_rdata !== rdata || rsp_err !== err) stable_ok = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        if (rsp_valid || !req_ready) stable_ok = 1'b0;
        wcnt = we_count - start_we;
        wa = last_wa;
        wd = last_wd;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          hold;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          wcnt;
        logic [31:0] wa;
        logic [31:0] wd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                                input logic err, input logic [31:0] rdata, input int lat,
                                input int wcnt, input logic [31:0] wa, input logic [31:0] wd);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata; v.hold = hold;
        v.err = err; v.rdata = rdata; v.lat = lat; v.wcnt = wcnt; v.wa = wa; v.wd = wd;
        return v;
    endfunction

    initial begin
        logic        o_err, m_err;
        logic [31:0] o_rd, m_rd, o_wa, o_wd, m_wa, m_wd;
        int          o_lat, m_lat, o_wc, m_wc, bad_words, start_we;
        logic        o_stable;

        n_checks = 0; n_pass = 0;
        for (int i = 0; i < AW; i++) ref_mem[i] = 32'(i);

        // Memory word i = i, then the spec's walk through loads/stores.
        vecs.push_back(mk(0, 2'd2, 0, 32'h14, 32'h0,        0, 0, 32'h0000_0005, 2, 0, 0, 0));
        vecs.push_back(mk(1, 2'd0, 0, 32'h09, 32'h0000_00AB, 0, 0, 32'h0, 3, 1, 32'd2, 32'h0000_AB02));
        vecs.push_back(mk(0, 2'd0, 0, 32'h09, 32'h0,        5, 0, 32'hFFFF_FFAB, 2, 0, 0, 0));
        vecs.push_back(mk(0, 2'd0, 1, 32'h09, 32'h0,        0, 0, 32'h0000_00AB, 2, 0, 0, 0));
        vecs.push_back(mk(0, 2'd1, 0, 32'h7E, 32'h0,        0, 0, 32'h0000_0000, 2, 0, 0, 0));
        vecs.push_back(mk(0, 2'd1, 0, 32'h7C, 32'h0,        0, 0, 32'h0000_001F, 2, 0, 0, 0));
        vecs.push_back(mk(0, 2'd2, 0, 32'h80, 32'h0,        0, 1, 32'h0, 1, 0, 0, 0));
`ifdef LSU_MISALIGN_TRAP_EN
        vecs.push_back(mk(1, 2'd2, 0, 32'h06, 32'hDEAD_BEEF, 0, 1, 32'h0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 2'd2, 0, 32'h04, 32'h0,        0, 0, 32'h0000_0001, 2, 0, 0, 0));
`else
        vecs.push_back(mk(1, 2'd2, 0, 32'h06, 32'hDEAD_BEEF, 0, 0, 32'h0, 2, 1, 32'd1, 32'hDEAD_BEEF));
        vecs.push_back(mk(0, 2'd2, 0, 32'h04, 32'h0,        0, 0, 32'hDEAD_BEEF, 2, 0, 0, 0));
`endif
        vecs.push_back(mk(0, 2'd3, 0, 32'h00, 32'h0,        0, 1, 32'h0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 2'd1, 0, 32'h12, 32'h1234_ABCD, 0, 0, 32'h0, 3, 1, 32'd4, 32'hABCD_0004));
        vecs.push_back(mk(0, 2'd1, 0, 32'h12, 32'h0,        0, 0, 32'hFFFF_ABCD, 2, 0, 0, 0));
        vecs.push_back(mk(0, 2'd0, 0, 32'h13, 32'h0,        0, 0, 32'hFFFF_FFAB, 2, 0, 0, 0));
        vecs.push_back(mk(0, 2'd0, 1, 32'h10, 32'h0,        0, 0, 32'h0000_0004, 2, 0, 0, 0));
`ifdef LSU_MISALIGN_TRAP_EN
        vecs.push_back(mk(0, 2'd1, 0, 32'h13, 32'h0,        0, 1, 32'h0, 1, 0, 0, 0));
`else
        vecs.push_back(mk(0, 2'd1, 0, 32'h13, 32'h0,        0, 0, 32'hFFFF_ABCD, 2, 0, 0, 0));
`endif
        vecs.push_back(mk(1, 2'd0, 0, 32'h7F, 32'h0000_0080, 0, 0, 32'h0, 3, 1, 32'd31, 32'h8000_001F));
        vecs.push_back(mk(0, 2'd0, 0, 32'h7F, 32'h0,        0, 0, 32'hFFFF_FF80, 2, 0, 0, 0));
        vecs.push_back(mk(1, 2'd0, 0, 32'h80, 32'h0000_0055, 0, 1, 32'h0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 2'd2, 1, 32'h7C, 32'h0,        0, 0, 32'h8000_001F, 2, 0, 0, 0));
        vecs.push_back(mk(1, 2'd2, 0, 32'h08, 32'h1234_5678, 2, 0, 32'h0, 2, 1, 32'd2, 32'h1234_5678));
        vecs.push_back(mk(0, 2'd1, 1, 32'h0A, 32'h0,        0, 0, 32'h0000_1234, 2, 0, 0, 0));

        // Reset: held low, outputs checked while asserted and after release.
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check32("rst_req_ready", 32'(req_ready), 32'd1);
        check32("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check32("rst_mem_we", 32'(mem_we), 32'd0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check32("rel_req_ready", 32'(req_ready), 32'd1);
        check32("rel_state", 32'(dbg_state), 32'(ST_IDLE));
        check32("rel_rsp_err", 32'(rsp_err), 32'd0);
        check32("rel_rsp_rdata", rsp_rdata, 32'h0);

        foreach (vecs[i]) begin
            model_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                      m_err, m_rd, m_lat, m_wc, m_wa, m_wd);
            do_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, vecs[i].hold,
                   o_err, o_rd, o_lat, o_wc, o_wa, o_wd, o_stable);
            check32($sformatf("v%0d_err", i), 32'(o_err), 32'(vecs[i].err));
            check32($sformatf("v%0d_rdata", i), o_rd, vecs[i].rdata);
            check32($sformatf("v%0d_lat", i), 32'(o_lat), 32'(vecs[i].lat));
            check32($sformatf("v%0d_wcnt", i), 32'(o_wc), 32'(vecs[i].wcnt));
            check32($sformatf("v%0d_stable", i), 32'(o_stable), 32'd1);
            if (vecs[i].wcnt != 0) begin
                check32($sformatf("v%0d_waddr", i), o_wa, vecs[i].wa);
                check32($sformatf("v%0d_wdata", i), o_wd, vecs[i].wd);
            end
        end

        // Reset during the READ phase of a byte store: no write may follow.
        @(negedge clk);
        start_we = we_count;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h21; req_wdata = 32'h0000_0055;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check32("mid_state_read", 32'(dbg_state), 32'(ST_READ));
        rst = 1'b0; #1;
        check32("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check32("mid_rst_outputs", {mem_addr[15:0], mem_wd[7:0], 4'h0, mem_we, rsp_valid, rsp_err, req_ready}, 32'h1);
        check32("mid_rst_rdata", rsp_rdata, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(posedge clk); #1;
        check32("mid_rst_no_write", 32'(we_count - start_we), 32'd0);
        check32("mid_rst_ready", 32'(req_ready), 32'd1);

        // Randomized requests against the model.
        for (int k = 0; k < 150; k++) begin
            logic        r_we_i, r_uns_i;
            logic [1:0]  r_size_i;
            logic [31:0] r_addr_i, r_wd_i;
            int          r_hold;
            r_we_i   = 1'($urandom);
            r_size_i = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r_uns_i  = 1'($urandom);
            r_addr_i = $urandom_range(0, 4 * AW + 15);
            r_wd_i   = $urandom;
            r_hold   = $urandom_range(0, 3);
            model_req(r_we_i, r_size_i, r_uns_i, r_addr_i, r_wd_i, m_err, m_rd, m_lat, m_wc, m_wa, m_wd);
            exp_q.push_back(m_rd);
            do_req(r_we_i, r_size_i, r_uns_i, r_addr_i, r_wd_i, r_hold,
                   o_err, o_rd, o_lat, o_wc, o_wa, o_wd, o_stable);
            check32($sformatf("r%0d_rdata", k), o_rd, exp_q.pop_front());
            check32($sformatf("r%0d_err", k), 32'(o_err), 32'(m_err));
            check32($sformatf("r%0d_lat", k), 32'(o_lat), 32'(m_lat));
            check32($sformatf("r%0d_wcnt", k), 32'(o_wc), 32'(m_wc));
            check32($sformatf("r%0d_stable", k), 32'(o_stable), 32'd1);
            if (m_wc != 0) begin
                check32($sformatf("r%0d_waddr", k), o_wa, m_wa);
                check32($sformatf("r%0d_wdata", k), o_wd, m_wd);
            end
        end

        // Final memory image must match the model.
        bad_words = 0;
        for (int i = 0; i < AW; i++) if (mem[i] !== ref_mem[i]) bad_words++;
        check32("final_mem_image", 32'(bad_words), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
